// File: rtl/lock_supervisor.sv
// lock_supervisor: paces keypad digits into the lock_system datapath, judges each full code, counts failures and enforces lockout.
// Latency: a digit sampled at edge N drives sys_valid/sys_pwd in cycles N+1..N+2, GAP in N+3, key_ready returns at N+4.
// Backpressure: key_ready is high only in READY; key_valid strobes arriving at any other time are dropped, never buffered.
module lock_supervisor #(
  parameter int DIGITS      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int RELOCK_CYC  = 32,
  parameter int RESP_CYC    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       lock_req,
  output logic       key_ready,
  output logic       sys_lock,
  output logic       sys_valid,
  output logic [3:0] sys_pwd,
  input  logic       sys_error,
  input  logic       sys_unlck,
  output logic       door_open,
  output logic       alarm,
  output logic [2:0] fail_cnt
);

  // One shared down-counter times every state; size it for the longest interval.
  localparam int T_A  = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
  localparam int T_B  = (T_A > RESP_CYC) ? T_A : RESP_CYC;
  localparam int TMAX = (T_B > 2) ? T_B : 2;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] T_TWO     = TW'(2);
  localparam logic [TW-1:0] T_RESP    = TW'(RESP_CYC);
  localparam logic [TW-1:0] T_RELOCK  = TW'(RELOCK_CYC);
  localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYC);
  localparam logic [3:0]    N_DIGITS  = 4'(DIGITS);
  localparam logic [2:0]    N_FAIL    = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_RELOCK,
    S_READY,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    digit_cnt;

  logic          timer_last;
  logic [3:0]    digit_nxt;
  logic [2:0]    fail_nxt;
  logic          res_ok;
  logic          res_bad;

  // Shared decode: timer expiry, next digit count, saturated failure count, result classification.
  always_comb begin
    timer_last = (timer <= T_ONE);
    digit_nxt  = digit_cnt + 4'd1;
    fail_nxt   = (fail_cnt >= N_FAIL) ? N_FAIL : fail_cnt + 3'd1;
    res_ok     = sys_unlck && !sys_error;
    // Both flags high is contradictory and treated as a rejection.
    res_bad    = sys_error;
  end

  // Supervisor FSM; every output is a register so the datapath strobes cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RELOCK;
      timer     <= T_TWO;
      digit_cnt <= 4'd0;
      key_ready <= 1'b0;
      sys_lock  <= 1'b1;
      sys_valid <= 1'b0;
      sys_pwd   <= 4'd0;
      door_open <= 1'b0;
      alarm     <= 1'b0;
      fail_cnt  <= 3'd0;
    end else begin
      case (state)
        // Hold lock for two cycles and discard any partial code.
        S_RELOCK: begin
          digit_cnt <= 4'd0;
          door_open <= 1'b0;
          if (timer_last) begin
            state     <= S_READY;
            sys_lock  <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        // lock_req outranks a simultaneous digit; an abort never counts as a failure.
        S_READY: begin
          if (lock_req) begin
            state     <= S_RELOCK;
            timer     <= T_TWO;
            sys_lock  <= 1'b1;
            key_ready <= 1'b0;
          end else if (key_valid) begin
            state     <= S_SEND;
            timer     <= T_TWO;
            sys_pwd   <= key_digit;
            sys_valid <= 1'b1;
            key_ready <= 1'b0;
          end
        end

        // sys_pwd stays put for the whole two-cycle valid window.
        S_SEND: begin
          if (timer_last) begin
            state     <= S_GAP;
            sys_valid <= 1'b0;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        // One idle cycle between digits; the last digit hands over to result waiting.
        S_GAP: begin
          digit_cnt <= digit_nxt;
          if (digit_nxt == N_DIGITS) begin
            state <= S_WAIT;
            timer <= T_RESP;
          end else begin
            state     <= S_READY;
            key_ready <= 1'b1;
          end
        end

        // A result seen on the final timer cycle still wins over the timeout.
        S_WAIT: begin
          if (res_ok) begin
            state     <= S_OPEN;
            timer     <= T_RELOCK;
            fail_cnt  <= 3'd0;
            door_open <= 1'b1;
          end else if (res_bad || timer_last) begin
            fail_cnt <= fail_nxt;
            if (fail_nxt == N_FAIL) begin
              state <= S_LOCKOUT;
              timer <= T_LOCKOUT;
              alarm <= 1'b1;
            end else begin
              state    <= S_RELOCK;
              timer    <= T_TWO;
              sys_lock <= 1'b1;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end

        // Door stays open until the relock timer runs out or the user asks to relock.
        S_OPEN: begin
          if (lock_req || timer_last) begin
            state     <= S_RELOCK;
            timer     <= T_TWO;
            sys_lock  <= 1'b1;
            door_open <= 1'b0;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        // Keypad and relock requests are deaf during lockout; the failure history clears on exit.
        S_LOCKOUT: begin
          if (timer_last) begin
            state    <= S_RELOCK;
            timer    <= T_TWO;
            sys_lock <= 1'b1;
            alarm    <= 1'b0;
            fail_cnt <= 3'd0;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        default: begin
          state     <= S_RELOCK;
          timer     <= T_TWO;
          sys_lock  <= 1'b1;
          sys_valid <= 1'b0;
          key_ready <= 1'b0;
          door_open <= 1'b0;
          alarm     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor: directed scenarios plus randomized code attempts for lock_supervisor.
// Expected behaviour comes from a transaction-level model: digit timing windows, failure count, open/lockout durations.
// Inputs change on the falling edge, outputs are observed on the falling edge.
module tb_lock_supervisor;
  localparam int DIGITS      = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 16;
  localparam int RELOCK_CYC  = 32;
  localparam int RESP_CYC    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       lock_req = 1'b0;
  logic       sys_error = 1'b0;
  logic       sys_unlck = 1'b0;
  logic       key_ready, sys_lock, sys_valid, door_open, alarm;
  logic [3:0] sys_pwd;
  logic [2:0] fail_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_fail = 0;
  int pulses   = 0;
  logic [3:0] code [DIGITS];

  lock_supervisor #(
    .DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC),
    .RELOCK_CYC(RELOCK_CYC), .RESP_CYC(RESP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .lock_req(lock_req), .key_ready(key_ready), .sys_lock(sys_lock),
    .sys_valid(sys_valid), .sys_pwd(sys_pwd), .sys_error(sys_error),
    .sys_unlck(sys_unlck), .door_open(door_open), .alarm(alarm), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge sys_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, key_ready}, 1);
  endtask

  // Two lock cycles then READY; called on the first cycle of RELOCK.
  task automatic check_relock(input string tag);
    chk({tag, "_lock1"}, {31'd0, sys_lock}, 1);
    chk({tag, "_nrdy1"}, {31'd0, key_ready}, 0);
    chk({tag, "_door"}, {31'd0, door_open}, 0);
    tick();
    chk({tag, "_lock2"}, {31'd0, sys_lock}, 1);
    chk({tag, "_nrdy2"}, {31'd0, key_ready}, 0);
    tick();
    chk({tag, "_unlock"}, {31'd0, sys_lock}, 0);
    chk({tag, "_ready"}, {31'd0, key_ready}, 1);
  endtask

  // One digit: valid window N+1..N+2, gap at N+3, ready again at N+4 unless it was the last.
  task automatic send_digit(input logic [3:0] d, input bit last);
    wait_ready("wait_ready");
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
    key_digit = 4'($urandom);
    chk("valid_c1", {31'd0, sys_valid}, 1);
    chk("pwd_c1", {28'd0, sys_pwd}, {28'd0, d});
    chk("busy_c1", {31'd0, key_ready}, 0);
    tick();
    chk("valid_c2", {31'd0, sys_valid}, 1);
    chk("pwd_c2", {28'd0, sys_pwd}, {28'd0, d});
    tick();
    chk("gap", {31'd0, sys_valid}, 0);
    tick();
    chk("ready_back", {31'd0, key_ready}, last ? 0 : 1);
  endtask

  task automatic send_code();
    for (int j = 0; j < DIGITS; j++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_digit(code[j], j == DIGITS - 1);
    end
  endtask

  task automatic check_lockout();
    int n;
    int p0;
    logic seen_ready;
    n = 0;
    p0 = pulses;
    seen_ready = 1'b0;
    chk("alarm_on", {31'd0, alarm}, 1);
    while (alarm === 1'b1 && n < 200) begin
      seen_ready = seen_ready | key_ready;
      key_valid = 1'($urandom);
      key_digit = 4'($urandom);
      lock_req = 1'($urandom);
      n++;
      tick();
    end
    key_valid = 1'b0;
    lock_req = 1'b0;
    chk("alarm_len", n, LOCKOUT_CYC);
    chk("lockout_no_valid", pulses, p0);
    chk("lockout_no_ready", {31'd0, seen_ready}, 0);
    exp_fail = 0;
    chk("lockout_fail_clr", {29'd0, fail_cnt}, 0);
    check_relock("lockout_end");
  endtask

  // kind: 0 unlock, 1 error, 2 both high, 3 silent. Called on WAIT cycle 1.
  task automatic resolve(input int kind, input int dly);
    if (kind == 3) begin
      repeat (RESP_CYC - 1) tick();
      chk("wait_hold_fail", {29'd0, fail_cnt}, exp_fail);
      chk("wait_hold_lock", {31'd0, sys_lock}, 0);
      tick();
    end else begin
      repeat (dly) tick();
      sys_unlck = (kind == 0 || kind == 2);
      sys_error = (kind != 0);
      chk("pre_result_door", {31'd0, door_open}, 0);
      tick();
      sys_unlck = 1'b0;
      sys_error = 1'b0;
    end
    if (kind == 0) begin
      exp_fail = 0;
      chk("door_open", {31'd0, door_open}, 1);
      chk("fail_clr", {29'd0, fail_cnt}, 0);
    end else begin
      exp_fail = (exp_fail < MAX_FAIL) ? exp_fail + 1 : MAX_FAIL;
      chk("fail_cnt", {29'd0, fail_cnt}, exp_fail);
      chk("door_shut", {31'd0, door_open}, 0);
      if (exp_fail == MAX_FAIL) check_lockout();
      else check_relock("fail");
    end
  endtask

  task automatic check_open();
    int n;
    n = 0;
    while (door_open === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("open_len", n, RELOCK_CYC);
    check_relock("auto_relock");
  endtask

  task automatic open_early(input int k);
    repeat (k - 1) tick();
    chk("open_before_req", {31'd0, door_open}, 1);
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    chk("open_req_close", {31'd0, door_open}, 0);
    check_relock("user_relock");
  endtask

  task automatic abort_after(input int k, input bit with_key);
    for (int j = 0; j < k; j++) send_digit(code[j], 1'b0);
    lock_req = 1'b1;
    key_valid = with_key;
    key_digit = 4'($urandom);
    tick();
    lock_req = 1'b0;
    key_valid = 1'b0;
    chk("abort_no_valid", {31'd0, sys_valid}, 0);
    chk("abort_fail_same", {29'd0, fail_cnt}, exp_fail);
    check_relock("abort");
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_lock"}, {31'd0, sys_lock}, 1);
    chk({tag, "_valid"}, {31'd0, sys_valid}, 0);
    chk({tag, "_pwd"}, {28'd0, sys_pwd}, 0);
    chk({tag, "_ready"}, {31'd0, key_ready}, 0);
    chk({tag, "_door"}, {31'd0, door_open}, 0);
    chk({tag, "_alarm"}, {31'd0, alarm}, 0);
    chk({tag, "_fail"}, {29'd0, fail_cnt}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_fail = 0;
    check_relock(tag);
  endtask

  initial begin
    int k;
    int kind;
    int dly;

    // Reset values, then the two-cycle relock before the first key_ready.
    tick();
    tick();
    chk("rst_lock", {31'd0, sys_lock}, 1);
    chk("rst_valid", {31'd0, sys_valid}, 0);
    chk("rst_pwd", {28'd0, sys_pwd}, 0);
    chk("rst_ready", {31'd0, key_ready}, 0);
    chk("rst_door", {31'd0, door_open}, 0);
    chk("rst_alarm", {31'd0, alarm}, 0);
    chk("rst_fail", {29'd0, fail_cnt}, 0);
    rst_n = 1'b1;
    check_relock("post_rst");

    // Correct code 3,0,1,2 opens the door for the full relock period.
    code[0] = 4'd3; code[1] = 4'd0; code[2] = 4'd1; code[3] = 4'd2;
    send_code();
    resolve(0, 2);
    check_open();

    // Three rejected codes lead to lockout.
    for (int i = 0; i < MAX_FAIL; i++) begin
      for (int j = 0; j < DIGITS; j++) code[j] = 4'($urandom);
      send_code();
      resolve(1, i);
    end

    // Abort after two digits keeps the failure count, then a good code opens.
    send_code();
    resolve(1, 0);
    abort_after(2, 1'b0);
    abort_after(1, 1'b1);
    send_code();
    resolve(0, 0);
    check_open();

    // Silent datapath times out after RESP_CYC wait cycles.
    send_code();
    resolve(3, 0);

    // User relock on cycle 5 of OPEN.
    send_code();
    resolve(0, RESP_CYC - 1);
    open_early(5);

    // Contradictory result counts as failure.
    send_code();
    resolve(2, 3);

    // Asynchronous reset while a digit is being sent.
    wait_ready("pre_send_ready");
    key_valid = 1'b1;
    key_digit = 4'd9;
    tick();
    key_valid = 1'b0;
    chk("send_before_rst", {31'd0, sys_valid}, 1);
    async_reset_check("rst_send");

    // Asynchronous reset during lockout.
    while (exp_fail < MAX_FAIL - 1) begin
      send_code();
      resolve(1, 0);
    end
    send_code();
    sys_error = 1'b1;
    tick();
    sys_error = 1'b0;
    chk("lockout_entered", {31'd0, alarm}, 1);
    repeat (5) tick();
    async_reset_check("rst_lockout");

    // Randomized attempts against the transaction model.
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < DIGITS; j++) code[j] = 4'($urandom);
      if (DIGITS > 1 && $urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, DIGITS - 1);
        abort_after(k, 1'($urandom));
      end else begin
        kind = $urandom_range(0, 3);
        dly = $urandom_range(0, RESP_CYC - 1);
        send_code();
        resolve(kind, dly);
        if (kind == 0) begin
          if ($urandom_range(0, 1) == 0) check_open();
          else open_early($urandom_range(1, RELOCK_CYC - 1));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
